line_fill_engine: RTL and testbench

LINE_FILL_ENGINE -- requirements
Module: line_fill_engine

---
 rtl/line_fill_engine.sv | 175 +++++++++++++++++
 tb/tb_line_fill_engine.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_engine.sv
// Line fill engine: queues cache-miss line fetches, issues one memory burst at a time,
// and returns completed lines in allocation order. Define CRITICAL_WORD_FIRST_EN for wrapped bursts.
module line_fill_engine #(
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_SIZE  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_ENTRIES = 2
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         fetch_request,
    input  logic [ADDR_WIDTH-1:0]                        fetch_addr,
    output logic                                         fetch_ready,
    output logic                                         mem_req_valid,
    output logic [ADDR_WIDTH-1:0]                        mem_req_addr,
    input  logic                                         mem_req_ready,
    input  logic                                         fetched_word_valid,
    input  logic [DATA_WIDTH-1:0]                        mem_data,
    output logic                                         critical_word_valid,
    output logic [DATA_WIDTH-1:0]                        critical_word,
    output logic                                         line_fill_valid,
    output logic [ADDR_WIDTH-1:0]                        line_fill_addr,
    output logic [(BLOCK_SIZE/(DATA_WIDTH/8))*DATA_WIDTH-1:0] line_fill_o,
    input  logic                                         line_allocated_ack
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int WORDS  = BLOCK_SIZE / BYTES;
    localparam int OFF_W  = $clog2(WORDS);
    localparam int BOFF_W = $clog2(BYTES);
    localparam int PTR_W  = $clog2(NUM_ENTRIES);

    typedef enum logic [1:0] {FREE, PENDING, FILLING, DONE} entry_state_t;

    entry_state_t          state_reg  [NUM_ENTRIES];
    entry_state_t          state_next [NUM_ENTRIES];
    logic [ADDR_WIDTH-1:0] base_reg   [NUM_ENTRIES];
    logic [OFF_W-1:0]      offset_reg [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0] line_reg   [NUM_ENTRIES][WORDS];

    logic [PTR_W-1:0]      alloc_ptr_reg, issue_ptr_reg, retire_ptr_reg;
    logic [OFF_W-1:0]      count_reg;
    logic [OFF_W-1:0]      req_offset;
    logic [OFF_W-1:0]      wr_idx;
    logic [NUM_ENTRIES-1:0] filling_vec;

    logic do_alloc, do_issue, do_write, do_last, do_retire;

    genvar gi;

    generate
        for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_filling
            assign filling_vec[gi] = (state_reg[gi] == FILLING);
        end
    endgenerate

    assign fetch_ready     = (state_reg[alloc_ptr_reg] == FREE);
    assign mem_req_valid   = (state_reg[issue_ptr_reg] == PENDING) && !(|filling_vec);
    assign line_fill_valid = (state_reg[retire_ptr_reg] == DONE);

    assign do_alloc  = fetch_request && fetch_ready;
    assign do_issue  = mem_req_valid && mem_req_ready;
    // Only one fill runs at a time and it always belongs to the issue-pointer entry.
    assign do_write  = fetched_word_valid && (state_reg[issue_ptr_reg] == FILLING);
    assign do_last   = do_write && (count_reg == OFF_W'(WORDS - 1));
    assign do_retire = line_allocated_ack && line_fill_valid;
    assign wr_idx    = offset_reg[issue_ptr_reg] + count_reg;

    assign mem_req_addr   = mem_req_valid
                          ? (base_reg[issue_ptr_reg] | (ADDR_WIDTH'(offset_reg[issue_ptr_reg]) << BOFF_W))
                          : '0;
    assign line_fill_addr = line_fill_valid ? base_reg[retire_ptr_reg] : '0;

    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_line_out
            assign line_fill_o[gi*DATA_WIDTH +: DATA_WIDTH] =
                line_fill_valid ? line_reg[retire_ptr_reg][gi] : '0;
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            state_next[i] = state_reg[i];
            case (state_reg[i])
                FREE:    if (do_alloc && alloc_ptr_reg == PTR_W'(i))   state_next[i] = PENDING;
                PENDING: if (do_issue && issue_ptr_reg == PTR_W'(i))   state_next[i] = FILLING;
                FILLING: if (do_last && issue_ptr_reg == PTR_W'(i))    state_next[i] = DONE;
                DONE:    if (do_retire && retire_ptr_reg == PTR_W'(i)) state_next[i] = FREE;
                default: state_next[i] = state_reg[i];
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) state_reg[i] <= FREE;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) state_reg[i] <= state_next[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alloc_ptr_reg  <= '0;
            issue_ptr_reg  <= '0;
            retire_ptr_reg <= '0;
            count_reg      <= '0;
        end else begin
            if (do_alloc)  alloc_ptr_reg  <= alloc_ptr_reg + 1'b1;
            if (do_last)   issue_ptr_reg  <= issue_ptr_reg + 1'b1;
            if (do_retire) retire_ptr_reg <= retire_ptr_reg + 1'b1;
            if (do_issue)
                count_reg <= '0;
            else if (do_write)
                count_reg <= count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                base_reg[i]   <= '0;
                offset_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (do_alloc && alloc_ptr_reg == PTR_W'(i)) begin
                    base_reg[i]   <= fetch_addr & ~ADDR_WIDTH'(BLOCK_SIZE - 1);
                    offset_reg[i] <= req_offset;
                end
            end
        end
    end

    // Retired buffers are cleared so an idle line never shows stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++)
                for (int w = 0; w < WORDS; w++) line_reg[i][w] <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (do_retire && retire_ptr_reg == PTR_W'(i)) begin
                    for (int w = 0; w < WORDS; w++) line_reg[i][w] <= '0;
                end else if (do_write && issue_ptr_reg == PTR_W'(i)) begin
                    line_reg[i][wr_idx] <= mem_data;
                end
            end
        end
    end

`ifdef CRITICAL_WORD_FIRST_EN
    logic                  crit_valid_reg;
    logic [DATA_WIDTH-1:0] crit_word_reg;

    assign req_offset = fetch_addr[BOFF_W +: OFF_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crit_valid_reg <= 1'b0;
            crit_word_reg  <= '0;
        end else begin
            crit_valid_reg <= do_write && (count_reg == '0);
            if (do_write && count_reg == '0)
                crit_word_reg <= mem_data;
        end
    end

    assign critical_word_valid = crit_valid_reg;
    assign critical_word       = crit_word_reg;
`else
    assign req_offset          = '0;
    assign critical_word_valid = 1'b0;
    assign critical_word       = '0;
`endif

endmodule

// File: tb/tb_line_fill_engine.sv
// Directed bench for line_fill_engine: wrapped/sequential fill, back-to-back misses,
// full-queue retire with held request, and reset during a fill.
module tb_line_fill_engine;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BS = 32;
    localparam int NE = 2;
    localparam int WORDS = 8;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  fetch_request = 1'b0;
    logic [AW-1:0]         fetch_addr = '0;
    logic                  fetch_ready;
    logic                  mem_req_valid;
    logic [AW-1:0]         mem_req_addr;
    logic                  mem_req_ready = 1'b0;
    logic                  fetched_word_valid = 1'b0;
    logic [DW-1:0]         mem_data = '0;
    logic                  critical_word_valid;
    logic [DW-1:0]         critical_word;
    logic                  line_fill_valid;
    logic [AW-1:0]         line_fill_addr;
    logic [WORDS*DW-1:0]   line_fill_o;
    logic                  line_allocated_ack = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    line_fill_engine #(
        .DATA_WIDTH (DW),
        .BLOCK_SIZE (BS),
        .ADDR_WIDTH (AW),
        .NUM_ENTRIES(NE)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .fetch_request      (fetch_request),
        .fetch_addr         (fetch_addr),
        .fetch_ready        (fetch_ready),
        .mem_req_valid      (mem_req_valid),
        .mem_req_addr       (mem_req_addr),
        .mem_req_ready      (mem_req_ready),
        .fetched_word_valid (fetched_word_valid),
        .mem_data           (mem_data),
        .critical_word_valid(critical_word_valid),
        .critical_word      (critical_word),
        .line_fill_valid    (line_fill_valid),
        .line_fill_addr     (line_fill_addr),
        .line_fill_o        (line_fill_o),
        .line_allocated_ack (line_allocated_ack)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) cycle();
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req_valid: got %b want 0", mem_req_valid); end
        n_checks++; if (line_fill_valid !== 1'b0) begin n_fail++; $display("FAIL rst_line_fill_valid: got %b want 0", line_fill_valid); end
        n_checks++; if (critical_word_valid !== 1'b0) begin n_fail++; $display("FAIL rst_crit_valid: got %b want 0", critical_word_valid); end
        n_checks++; if (critical_word !== '0) begin n_fail++; $display("FAIL rst_crit_word: got %h want 0", critical_word); end
        n_checks++; if (line_fill_addr !== '0) begin n_fail++; $display("FAIL rst_line_addr: got %h want 0", line_fill_addr); end
        n_checks++; if (line_fill_o !== '0) begin n_fail++; $display("FAIL rst_line_data: got %h want 0", line_fill_o); end
        reset = 1'b0;
        cycle();
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL rst_fetch_ready: got %b want 1", fetch_ready); end
        $display("reset released");
    endtask

    task automatic test_critical_fill();
        logic [WORDS*DW-1:0] exp_line;
        logic [AW-1:0]       exp_req;
        logic [DW-1:0]       exp_crit;
        logic                exp_crit_valid;
        logic [DW-1:0]       exp_w5;
        int                  exp_pulses;
        int                  pulses;
`ifdef CRITICAL_WORD_FIRST_EN
        exp_req = 32'h1014; exp_crit = 32'hA0; exp_crit_valid = 1'b1; exp_w5 = 32'hA0; exp_pulses = 1;
        for (int i = 0; i < WORDS; i++) exp_line[i*DW +: DW] = 32'hA0 + ((i + 3) % WORDS);
`else
        exp_req = 32'h1000; exp_crit = 32'h0; exp_crit_valid = 1'b0; exp_w5 = 32'hA5; exp_pulses = 0;
        for (int i = 0; i < WORDS; i++) exp_line[i*DW +: DW] = 32'hA0 + i;
`endif
        fetch_addr = 32'h1014; fetch_request = 1'b1;
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL cf_fetch_ready: got %b want 1", fetch_ready); end
        cycle();
        fetch_request = 1'b0;
        n_checks++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL cf_req_valid: got %b want 1", mem_req_valid); end
        n_checks++; if (mem_req_addr !== exp_req) begin n_fail++; $display("FAIL cf_req_addr: got %h want %h", mem_req_addr, exp_req); end
        cycle();
        n_checks++; if (mem_req_addr !== exp_req) begin n_fail++; $display("FAIL cf_req_addr_hold: got %h want %h", mem_req_addr, exp_req); end
        mem_req_ready = 1'b1;
        cycle();
        mem_req_ready = 1'b0;
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL cf_req_after_accept: got %b want 0", mem_req_valid); end
        pulses = 0;
        for (int k = 0; k < WORDS; k++) begin
            fetched_word_valid = 1'b1; mem_data = 32'hA0 + k;
            cycle();
            if (critical_word_valid === 1'b1) pulses++;
            if (k == 0) begin
                n_checks++; if (critical_word_valid !== exp_crit_valid) begin n_fail++; $display("FAIL cf_crit_valid: got %b want %b", critical_word_valid, exp_crit_valid); end
                n_checks++; if (critical_word !== exp_crit) begin n_fail++; $display("FAIL cf_crit_word: got %h want %h", critical_word, exp_crit); end
            end
        end
        fetched_word_valid = 1'b0;
        n_checks++; if (pulses != exp_pulses) begin n_fail++; $display("FAIL cf_crit_pulses: got %0d want %0d", pulses, exp_pulses); end
        n_checks++; if (line_fill_valid !== 1'b1) begin n_fail++; $display("FAIL cf_line_valid: got %b want 1", line_fill_valid); end
        n_checks++; if (line_fill_addr !== 32'h1000) begin n_fail++; $display("FAIL cf_line_addr: got %h want 00001000", line_fill_addr); end
        n_checks++; if (line_fill_o[5*DW +: DW] !== exp_w5) begin n_fail++; $display("FAIL cf_word5: got %h want %h", line_fill_o[5*DW +: DW], exp_w5); end
        n_checks++; if (line_fill_o !== exp_line) begin n_fail++; $display("FAIL cf_line_data: got %h want %h", line_fill_o, exp_line); end
        line_allocated_ack = 1'b1;
        cycle();
        line_allocated_ack = 1'b0;
        n_checks++; if (line_fill_valid !== 1'b0) begin n_fail++; $display("FAIL cf_retired_valid: got %b want 0", line_fill_valid); end
        n_checks++; if (line_fill_o !== '0) begin n_fail++; $display("FAIL cf_retired_data: got %h want 0", line_fill_o); end
        $display("fill 0x1014 retired, critical pulses %0d", pulses);
    endtask

    task automatic test_back_to_back();
        fetch_request = 1'b1; fetch_addr = 32'h2000;
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_first: got %b want 1", fetch_ready); end
        cycle();
        fetch_addr = 32'h3000;
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_second: got %b want 1", fetch_ready); end
        cycle();
        fetch_request = 1'b0;
        n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full: got %b want 0", fetch_ready); end
        n_checks++; if (mem_req_addr !== 32'h2000) begin n_fail++; $display("FAIL b2b_req_addr1: got %h want 00002000", mem_req_addr); end
        mem_req_ready = 1'b1;
        cycle();
        for (int k = 0; k < WORDS; k++) begin
            n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early_req: word %0d got %b want 0", k, mem_req_valid); end
            fetched_word_valid = 1'b1; mem_data = 32'hB0 + k;
            cycle();
        end
        fetched_word_valid = 1'b0;
        n_checks++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_req_valid2: got %b want 1", mem_req_valid); end
        n_checks++; if (mem_req_addr !== 32'h3000) begin n_fail++; $display("FAIL b2b_req_addr2: got %h want 00003000", mem_req_addr); end
        cycle();
        mem_req_ready = 1'b0;
        for (int k = 0; k < WORDS; k++) begin
            fetched_word_valid = 1'b1; mem_data = 32'hC0 + k;
            cycle();
        end
        fetched_word_valid = 1'b0;
        $display("back-to-back fills 0x2000, 0x3000 complete");
    endtask

    task automatic test_full_queue();
        logic [WORDS*DW-1:0] line_b;
        logic [WORDS*DW-1:0] line_c;
        for (int i = 0; i < WORDS; i++) begin
            line_b[i*DW +: DW] = 32'hB0 + i;
            line_c[i*DW +: DW] = 32'hC0 + i;
        end
        n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL fq_ready_full: got %b want 0", fetch_ready); end
        n_checks++; if (line_fill_addr !== 32'h2000) begin n_fail++; $display("FAIL fq_line_addr1: got %h want 00002000", line_fill_addr); end
        n_checks++; if (line_fill_o !== line_b) begin n_fail++; $display("FAIL fq_line_data1: got %h want %h", line_fill_o, line_b); end
        fetch_request = 1'b1; fetch_addr = 32'h4000; line_allocated_ack = 1'b1;
        cycle();
        line_allocated_ack = 1'b0;
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL fq_ready_freed: got %b want 1", fetch_ready); end
        n_checks++; if (line_fill_addr !== 32'h3000) begin n_fail++; $display("FAIL fq_line_addr2: got %h want 00003000", line_fill_addr); end
        n_checks++; if (line_fill_o !== line_c) begin n_fail++; $display("FAIL fq_line_data2: got %h want %h", line_fill_o, line_c); end
        cycle();
        fetch_request = 1'b0;
        n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL fq_ready_after_alloc: got %b want 0", fetch_ready); end
        n_checks++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL fq_req_valid: got %b want 1", mem_req_valid); end
        n_checks++; if (mem_req_addr !== 32'h4000) begin n_fail++; $display("FAIL fq_req_addr: got %h want 00004000", mem_req_addr); end
        line_allocated_ack = 1'b1;
        cycle();
        line_allocated_ack = 1'b0;
        n_checks++; if (line_fill_valid !== 1'b0) begin n_fail++; $display("FAIL fq_valid_after_retire: got %b want 0", line_fill_valid); end
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL fq_ready_after_retire: got %b want 1", fetch_ready); end
        $display("full-queue retire with held request 0x4000 allocated");
    endtask

    task automatic test_reset_mid_fill();
        logic          exp_crit_valid;
        logic [DW-1:0] exp_crit;
`ifdef CRITICAL_WORD_FIRST_EN
        exp_crit_valid = 1'b1; exp_crit = 32'hD0;
`else
        exp_crit_valid = 1'b0; exp_crit = 32'h0;
`endif
        mem_req_ready = 1'b1;
        cycle();
        mem_req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            fetched_word_valid = 1'b1; mem_data = 32'hD0 + k;
            cycle();
            if (k == 0) begin
                n_checks++; if (critical_word_valid !== exp_crit_valid) begin n_fail++; $display("FAIL rmf_crit_valid: got %b want %b", critical_word_valid, exp_crit_valid); end
                n_checks++; if (critical_word !== exp_crit) begin n_fail++; $display("FAIL rmf_crit_word: got %h want %h", critical_word, exp_crit); end
            end
        end
        mem_data = 32'hD3;
        reset = 1'b1;
        #1;
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_req_valid: got %b want 0", mem_req_valid); end
        n_checks++; if (critical_word !== '0) begin n_fail++; $display("FAIL rmf_crit_word_rst: got %h want 0", critical_word); end
        n_checks++; if (line_fill_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_line_valid: got %b want 0", line_fill_valid); end
        n_checks++; if (line_fill_o !== '0) begin n_fail++; $display("FAIL rmf_line_data: got %h want 0", line_fill_o); end
        fetched_word_valid = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL rmf_fetch_ready: got %b want 1", fetch_ready); end
        for (int k = 0; k < 5; k++) begin
            fetched_word_valid = 1'b1; mem_data = 32'hE0 + k;
            cycle();
            n_checks++; if (critical_word_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_stray_crit: word %0d got %b want 0", k, critical_word_valid); end
            n_checks++; if (line_fill_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_stray_line: word %0d got %b want 0", k, line_fill_valid); end
        end
        fetched_word_valid = 1'b0;
        n_checks++; if (critical_word !== '0) begin n_fail++; $display("FAIL rmf_stray_crit_word: got %h want 0", critical_word); end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_stray_req: got %b want 0", mem_req_valid); end
        $display("reset during fill, stray words dropped");
    endtask

    initial begin
        test_reset();
        test_critical_fill();
        test_back_to_back();
        test_full_queue();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
